// File: rtl/cpu_types_pkg.sv
// Shared types for the multicycle MIPS control path: the word type, ALU
// operation codes, FSM states, select-field encodings, instruction classes
// and the opcode/funct values the decoder recognises.
package cpu_types_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam int unsigned OPCODE_W = 6;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'b0000,
        ALU_SRL  = 4'b0001,
        ALU_ADD  = 4'b0010,
        ALU_SUB  = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_OR   = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_NOR  = 4'b0111,
        ALU_SLT  = 4'b1010,
        ALU_SLTU = 4'b1011
    } aluop_t;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } mc_state_t;

    typedef enum logic [1:0] {
        PC_PC4    = 2'b00,
        PC_RS     = 2'b01,
        PC_JUMP   = 2'b10,
        PC_BRANCH = 2'b11
    } pcsel_t;

    typedef enum logic [1:0] {
        PB_RT    = 2'b00,
        PB_SHAMT = 2'b01,
        PB_IMM   = 2'b10,
        PB_16    = 2'b11
    } portbsel_t;

    typedef enum logic [1:0] {
        RW_RD  = 2'b00,
        RW_RT  = 2'b01,
        RW_R31 = 2'b10
    } regwsel_t;

    typedef enum logic [1:0] {
        WD_ALU = 2'b00,
        WD_MEM = 2'b01,
        WD_PC4 = 2'b10
    } wdatsel_t;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JUMP   = 3'd4,
        CLS_JR     = 3'd5,
        CLS_JAL    = 3'd6,
        CLS_HALT   = 3'd7
    } instr_class_t;

    // Opcodes
    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'h02;
    localparam logic [OPCODE_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPCODE_W-1:0] OP_BNE   = 6'h05;
    localparam logic [OPCODE_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPCODE_W-1:0] OP_SLTIU = 6'h0B;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPCODE_W-1:0] OP_XORI  = 6'h0E;
    localparam logic [OPCODE_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'h23;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'h2B;
    localparam logic [OPCODE_W-1:0] OP_HALT  = 6'h3F;

    // R-type funct codes
    localparam logic [OPCODE_W-1:0] FN_SLL  = 6'h00;
    localparam logic [OPCODE_W-1:0] FN_SRL  = 6'h02;
    localparam logic [OPCODE_W-1:0] FN_SLLV = 6'h04;
    localparam logic [OPCODE_W-1:0] FN_SRLV = 6'h06;
    localparam logic [OPCODE_W-1:0] FN_JR   = 6'h08;
    localparam logic [OPCODE_W-1:0] FN_ADD  = 6'h20;
    localparam logic [OPCODE_W-1:0] FN_ADDU = 6'h21;
    localparam logic [OPCODE_W-1:0] FN_SUB  = 6'h22;
    localparam logic [OPCODE_W-1:0] FN_SUBU = 6'h23;
    localparam logic [OPCODE_W-1:0] FN_AND  = 6'h24;
    localparam logic [OPCODE_W-1:0] FN_OR   = 6'h25;
    localparam logic [OPCODE_W-1:0] FN_XOR  = 6'h26;
    localparam logic [OPCODE_W-1:0] FN_NOR  = 6'h27;
    localparam logic [OPCODE_W-1:0] FN_SLT  = 6'h2A;
    localparam logic [OPCODE_W-1:0] FN_SLTU = 6'h2B;

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder.
// In : ir        - instruction register
// Out: alu_op, porta_sel, portb_sel, imm_ext_sel - ALU operand/op fields
//      regw_sel  - destination register select for ALU/load writes
//      cls       - instruction class steering the sequencing FSM
//      illegal   - unknown opcode or unknown R-type funct
module instr_decode
    import cpu_types_pkg::*;
(
    input  word_t        ir,
    output aluop_t       alu_op,
    output logic         porta_sel,
    output portbsel_t    portb_sel,
    output logic         imm_ext_sel,
    output regwsel_t     regw_sel,
    output instr_class_t cls,
    output logic         illegal
);

    logic [OPCODE_W-1:0] opcode;
    logic [OPCODE_W-1:0] funct;
    logic                unused_ir_bits;

    assign opcode         = ir[31:26];
    assign funct          = ir[5:0];
    assign unused_ir_bits = ^ir[25:6];

    // Field decode; non-ALU instructions leave the ALU fields at zero.
    always_comb begin
        alu_op      = ALU_SLL;
        porta_sel   = 1'b0;
        portb_sel   = PB_RT;
        imm_ext_sel = 1'b0;
        regw_sel    = RW_RT;
        cls         = CLS_ALU;
        illegal     = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                regw_sel = RW_RD;
                case (funct)
                    FN_SLL:  begin alu_op = ALU_SLL; portb_sel = PB_SHAMT; end
                    FN_SRL:  begin alu_op = ALU_SRL; portb_sel = PB_SHAMT; end
                    FN_SLLV: alu_op = ALU_SLL;
                    FN_SRLV: alu_op = ALU_SRL;
                    FN_JR:   cls    = CLS_JR;
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLT:  alu_op = ALU_SLT;
                    FN_SLTU: alu_op = ALU_SLTU;
                    default: illegal = 1'b1;
                endcase
            end
            OP_J:   cls = CLS_JUMP;
            OP_JAL: cls = CLS_JAL;
            OP_BEQ, OP_BNE: begin
                cls         = CLS_BRANCH;
                alu_op      = ALU_SUB;
                imm_ext_sel = 1'b1;
            end
            OP_ADDIU: begin alu_op = ALU_ADD;  portb_sel = PB_IMM; imm_ext_sel = 1'b1; end
            OP_SLTI:  begin alu_op = ALU_SLT;  portb_sel = PB_IMM; imm_ext_sel = 1'b1; end
            OP_SLTIU: begin alu_op = ALU_SLTU; portb_sel = PB_IMM; imm_ext_sel = 1'b1; end
            OP_ANDI:  begin alu_op = ALU_AND;  portb_sel = PB_IMM; end
            OP_ORI:   begin alu_op = ALU_OR;   portb_sel = PB_IMM; end
            OP_XORI:  begin alu_op = ALU_XOR;  portb_sel = PB_IMM; end
            // LUI shifts the zero-extended immediate left by the constant 16
            OP_LUI: begin
                alu_op    = ALU_SLL;
                porta_sel = 1'b1;
                portb_sel = PB_16;
            end
            OP_LW: begin
                cls = CLS_LOAD; alu_op = ALU_ADD; portb_sel = PB_IMM; imm_ext_sel = 1'b1;
            end
            OP_SW: begin
                cls = CLS_STORE; alu_op = ALU_ADD; portb_sel = PB_IMM; imm_ext_sel = 1'b1;
            end
            OP_HALT: cls     = CLS_HALT;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle sequencing controller: FETCH/DECODE/EXEC/MEM/WB/HALT FSM,
// instruction register, memory wait timeout and retired-instruction counter.
// In : CLK, RST (sync, active-high), imemload, ihit, dhit, brTake
// Out: ir, memory/regfile/PC enables, datapath selects, aluOp,
//      sticky halt/err, instret, state (debug)
module multicycle_control
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  word_t            imemload,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             brTake,
    output word_t            ir,
    output logic             iREN,
    output logic             dREN,
    output logic             dWEN,
    output logic             regWEN,
    output logic             pcWEN,
    output pcsel_t           pc_sel,
    output aluop_t           aluOp,
    output portbsel_t        portb_sel,
    output logic             porta_sel,
    output logic             immExt_sel,
    output regwsel_t         regW_sel,
    output wdatsel_t         wMemReg_sel,
    output logic             halt,
    output logic             err,
    output logic [CNT_W-1:0] instret,
    output mc_state_t        state
);

    // Counter holds 0..TIMEOUT-1; expiry is the last wait cycle without a hit.
    localparam int unsigned WAIT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int unsigned WAIT_LIMIT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    mc_state_t        state_q, state_d;
    word_t            ir_q, ir_d;
    logic             halt_q, halt_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    aluop_t       dec_alu_op;
    logic         dec_porta_sel;
    portbsel_t    dec_portb_sel;
    logic         dec_imm_ext_sel;
    regwsel_t     dec_regw_sel;
    instr_class_t dec_cls;
    logic         dec_illegal;

    logic     iren_c, dren_c, dwen_c, regwen_c, pcwen_c;
    logic     alu_en_c;
    logic     wait_expired_c;
    pcsel_t   pc_sel_c;
    regwsel_t regw_sel_c;
    wdatsel_t wdat_sel_c;

    instr_decode u_decode (
        .ir          (ir_q),
        .alu_op      (dec_alu_op),
        .porta_sel   (dec_porta_sel),
        .portb_sel   (dec_portb_sel),
        .imm_ext_sel (dec_imm_ext_sel),
        .regw_sel    (dec_regw_sel),
        .cls         (dec_cls),
        .illegal     (dec_illegal)
    );

    assign wait_expired_c = (TIMEOUT != 0) && (wait_cnt_q == WAIT_W'(WAIT_LIMIT));

    // State register and architectural flops
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= FETCH;
            ir_q       <= '0;
            halt_q     <= 1'b0;
            err_q      <= 1'b0;
            instret_q  <= '0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            halt_q     <= halt_d;
            err_q      <= err_d;
            instret_q  <= instret_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        halt_d     = halt_q;
        err_d      = err_q;
        iren_c     = 1'b0;
        dren_c     = 1'b0;
        dwen_c     = 1'b0;
        regwen_c   = 1'b0;
        pcwen_c    = 1'b0;
        alu_en_c   = 1'b0;
        pc_sel_c   = PC_PC4;
        regw_sel_c = RW_RD;
        wdat_sel_c = WD_ALU;

        case (state_q)
            FETCH: begin
                iren_c = 1'b1;
                if (ihit) begin
                    ir_d    = imemload;
                    state_d = DECODE;
                end else if (wait_expired_c) begin
                    state_d = HALT;
                    halt_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            DECODE: begin
                if (dec_illegal) begin
                    state_d = HALT;
                    halt_d  = 1'b1;
                    err_d   = 1'b1;
                end else if (dec_cls == CLS_HALT) begin
                    state_d = HALT;
                    halt_d  = 1'b1;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                alu_en_c = 1'b1;
                case (dec_cls)
                    CLS_JUMP: begin
                        pcwen_c = 1'b1; pc_sel_c = PC_JUMP; state_d = FETCH;
                    end
                    CLS_JR: begin
                        pcwen_c = 1'b1; pc_sel_c = PC_RS; state_d = FETCH;
                    end
                    CLS_BRANCH: begin
                        pcwen_c  = 1'b1;
                        pc_sel_c = brTake ? PC_BRANCH : PC_PC4;
                        state_d  = FETCH;
                    end
                    CLS_LOAD, CLS_STORE: state_d = MEM;
                    default:             state_d = WB;
                endcase
            end
            MEM: begin
                // Only loads and stores reach MEM
                alu_en_c = 1'b1;
                if (dec_cls == CLS_LOAD) dren_c = 1'b1;
                else                     dwen_c = 1'b1;
                if (dhit) begin
                    if (dec_cls == CLS_LOAD) begin
                        state_d = WB;
                    end else begin
                        pcwen_c = 1'b1;
                        state_d = FETCH;
                    end
                end else if (wait_expired_c) begin
                    state_d = HALT;
                    halt_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            WB: begin
                alu_en_c   = 1'b1;
                regwen_c   = 1'b1;
                pcwen_c    = 1'b1;
                state_d    = FETCH;
                regw_sel_c = dec_regw_sel;
                case (dec_cls)
                    CLS_JAL: begin
                        regw_sel_c = RW_R31;
                        wdat_sel_c = WD_PC4;
                        pc_sel_c   = PC_JUMP;
                    end
                    CLS_LOAD: wdat_sel_c = WD_MEM;
                    default:  wdat_sel_c = WD_ALU;
                endcase
            end
            HALT:    state_d = HALT;
            default: state_d = FETCH;
        endcase

        // Wait counter restarts whenever the state changes
        if ((state_q == FETCH || state_q == MEM) && (state_d == state_q)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end else begin
            wait_cnt_d = '0;
        end

        instret_d = instret_q + CNT_W'(pcwen_c);
    end

    // RST gates every enable and select so an aborted instruction commits nothing
    assign iREN        = iren_c   & ~RST;
    assign dREN        = dren_c   & ~RST;
    assign dWEN        = dwen_c   & ~RST;
    assign regWEN      = regwen_c & ~RST;
    assign pcWEN       = pcwen_c  & ~RST;
    assign pc_sel      = RST ? PC_PC4 : pc_sel_c;
    assign regW_sel    = RST ? RW_RD  : regw_sel_c;
    assign wMemReg_sel = RST ? WD_ALU : wdat_sel_c;
    assign aluOp       = (RST || !alu_en_c) ? ALU_SLL : dec_alu_op;
    assign porta_sel   = ~RST & alu_en_c & dec_porta_sel;
    assign portb_sel   = (RST || !alu_en_c) ? PB_RT : dec_portb_sel;
    assign immExt_sel  = ~RST & alu_en_c & dec_imm_ext_sel;

    assign ir      = ir_q;
    assign halt    = halt_q;
    assign err     = err_q;
    assign instret = instret_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control (TIMEOUT=4). Each cycle's
// expected control word is queued when that cycle's inputs are driven and
// popped/compared against the DUT on the falling edge.
module tb_multicycle_control;
    import cpu_types_pkg::*;

    logic             CLK = 1'b0;
    logic             RST;
    word_t            imemload;
    logic             ihit, dhit, brTake;
    word_t            ir;
    logic             iREN, dREN, dWEN, regWEN, pcWEN;
    pcsel_t           pc_sel;
    aluop_t           aluOp;
    portbsel_t        portb_sel;
    logic             porta_sel, immExt_sel;
    regwsel_t         regW_sel;
    wdatsel_t         wMemReg_sel;
    logic             halt, err;
    logic [31:0]      instret;
    mc_state_t        state;

    multicycle_control #(.TIMEOUT(4), .CNT_W(32)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .imemload    (imemload),
        .ihit        (ihit),
        .dhit        (dhit),
        .brTake      (brTake),
        .ir          (ir),
        .iREN        (iREN),
        .dREN        (dREN),
        .dWEN        (dWEN),
        .regWEN      (regWEN),
        .pcWEN       (pcWEN),
        .pc_sel      (pc_sel),
        .aluOp       (aluOp),
        .portb_sel   (portb_sel),
        .porta_sel   (porta_sel),
        .immExt_sel  (immExt_sel),
        .regW_sel    (regW_sel),
        .wMemReg_sel (wMemReg_sel),
        .halt        (halt),
        .err         (err),
        .instret     (instret),
        .state       (state)
    );

    always #5 CLK = ~CLK;

    // enable bits {iREN, dREN, dWEN, regWEN, pcWEN}
    localparam logic [4:0] EN_NONE = 5'b00000;
    localparam logic [4:0] EN_I    = 5'b10000;
    localparam logic [4:0] EN_DR   = 5'b01000;
    localparam logic [4:0] EN_DW   = 5'b00100;
    localparam logic [4:0] EN_RW   = 5'b00010;
    localparam logic [4:0] EN_PC   = 5'b00001;

    // ALU field bundle {aluOp[3:0], porta_sel, portb_sel[1:0], immExt_sel}
    localparam logic [7:0] AF_NONE = 8'h00;
    localparam logic [7:0] AF_ADDU = {4'd2, 1'b0, 2'b00, 1'b0};
    localparam logic [7:0] AF_MEM  = {4'd2, 1'b0, 2'b10, 1'b1};
    localparam logic [7:0] AF_BR   = {4'd3, 1'b0, 2'b00, 1'b1};
    localparam logic [7:0] AF_LUI  = {4'd0, 1'b1, 2'b11, 1'b0};

    typedef struct packed {
        mc_state_t  st;
        logic [4:0] en;
        logic [1:0] pcs;
        logic [1:0] rws;
        logic [1:0] wms;
        logic [1:0] he;   // {halt, err}
    } exp_t;

    exp_t       sb_q[$];
    logic [7:0] cur_af;
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input mc_state_t s, input logic [4:0] en,
                                input logic [1:0] pcs = 2'b00, input logic [1:0] rws = 2'b00,
                                input logic [1:0] wms = 2'b00, input logic [1:0] he = 2'b00);
        exp_t e;
        e.st = s; e.en = en; e.pcs = pcs; e.rws = rws; e.wms = wms; e.he = he;
        return e;
    endfunction

    // One clock cycle: drive inputs, queue expectation, compare on falling edge
    task automatic step(input string name, input logic ih, input logic dh,
                        input logic bt, input logic rst, input exp_t e);
        exp_t       x;
        logic [7:0] af_exp;
        ihit = ih; dhit = dh; brTake = bt; RST = rst;
        sb_q.push_back(e);
        @(negedge CLK);
        x = sb_q.pop_front();
        af_exp = ((x.st == EXEC || x.st == MEM || x.st == WB) && !rst) ? cur_af : AF_NONE;
        check({name, ".state"}, 32'(state), 32'(x.st));
        check({name, ".en"},    32'({iREN, dREN, dWEN, regWEN, pcWEN}), 32'(x.en));
        check({name, ".pcsel"}, 32'(pc_sel), 32'(x.pcs));
        check({name, ".regw"},  32'(regW_sel), 32'(x.rws));
        check({name, ".wdat"},  32'(wMemReg_sel), 32'(x.wms));
        check({name, ".flags"}, 32'({halt, err}), 32'(x.he));
        check({name, ".alu"},   32'({aluOp, porta_sel, portb_sel, immExt_sel}), 32'(af_exp));
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input string name, input mc_state_t cur, input logic [1:0] he);
        step(name, 1'b0, 1'b0, 1'b0, 1'b1, mk(cur, EN_NONE, 2'b00, 2'b00, 2'b00, he));
        RST = 1'b0;
        check({name, ".post_state"},   32'(state), 32'(FETCH));
        check({name, ".post_ir"},      ir, 32'h0);
        check({name, ".post_instret"}, instret, 32'd0);
        check({name, ".post_flags"},   32'({halt, err}), 32'd0);
    endtask

    // Fetch (hit on first cycle) + decode for the word in imemload
    task automatic fetch_decode(input string name);
        step({name, ".f"}, 1'b1, 1'b0, 1'b0, 1'b0, mk(FETCH, EN_I));
        step({name, ".d"}, 1'b0, 1'b1, 1'b0, 1'b0, mk(DECODE, EN_NONE));
    endtask

    task automatic run_addu(input string name);
        imemload = 32'h00221821; cur_af = AF_ADDU;
        fetch_decode(name);
        step({name, ".e"},  1'b1, 1'b1, 1'b0, 1'b0, mk(EXEC, EN_NONE));
        step({name, ".wb"}, 1'b0, 1'b0, 1'b0, 1'b0, mk(WB, EN_RW | EN_PC));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; ihit = 1'b0; dhit = 1'b0; brTake = 1'b0;
        imemload = 32'h0; cur_af = AF_NONE;
        @(posedge CLK);
        #1;
        do_reset("reset", FETCH, 2'b00);

        // ADDU, zero-wait
        run_addu("addu");
        check("addu.ir", ir, 32'h00221821);
        check("addu.instret", instret, 32'd1);

        // LW with dhit on the 4th MEM cycle (hit on the timeout limit wins)
        imemload = 32'h8C220004; cur_af = AF_MEM;
        fetch_decode("lw");
        step("lw.e",  1'b0, 1'b1, 1'b0, 1'b0, mk(EXEC, EN_NONE));
        step("lw.m1", 1'b1, 1'b0, 1'b0, 1'b0, mk(MEM, EN_DR));
        step("lw.m2", 1'b0, 1'b0, 1'b0, 1'b0, mk(MEM, EN_DR));
        step("lw.m3", 1'b0, 1'b0, 1'b0, 1'b0, mk(MEM, EN_DR));
        step("lw.m4", 1'b0, 1'b1, 1'b0, 1'b0, mk(MEM, EN_DR));
        step("lw.wb", 1'b0, 1'b0, 1'b0, 1'b0, mk(WB, EN_RW | EN_PC, 2'b00, 2'b01, 2'b01));
        check("lw.instret", instret, 32'd2);

        // BEQ taken, then not taken
        imemload = 32'h10210003; cur_af = AF_BR;
        fetch_decode("beq1");
        step("beq1.e", 1'b0, 1'b0, 1'b1, 1'b0, mk(EXEC, EN_PC, 2'b11));
        fetch_decode("beq0");
        step("beq0.e", 1'b0, 1'b0, 1'b0, 1'b0, mk(EXEC, EN_PC, 2'b00));
        check("beq.instret", instret, 32'd4);

        // JAL
        imemload = 32'h0C000010; cur_af = AF_NONE;
        fetch_decode("jal");
        step("jal.e",  1'b0, 1'b0, 1'b0, 1'b0, mk(EXEC, EN_NONE));
        step("jal.wb", 1'b0, 1'b0, 1'b0, 1'b0, mk(WB, EN_RW | EN_PC, 2'b10, 2'b10, 2'b10));

        // SW, zero-wait
        imemload = 32'hAC220004; cur_af = AF_MEM;
        fetch_decode("sw");
        step("sw.e", 1'b0, 1'b0, 1'b0, 1'b0, mk(EXEC, EN_NONE));
        step("sw.m", 1'b0, 1'b1, 1'b0, 1'b0, mk(MEM, EN_DW | EN_PC));

        // J and JR
        imemload = 32'h08000004; cur_af = AF_NONE;
        fetch_decode("j");
        step("j.e", 1'b0, 1'b0, 1'b0, 1'b0, mk(EXEC, EN_PC, 2'b10));
        imemload = 32'h03E00008;
        fetch_decode("jr");
        step("jr.e", 1'b0, 1'b0, 1'b0, 1'b0, mk(EXEC, EN_PC, 2'b01));

        // LUI (port A immediate, port B constant 16)
        imemload = 32'h3C011234; cur_af = AF_LUI;
        fetch_decode("lui");
        step("lui.e",  1'b0, 1'b0, 1'b0, 1'b0, mk(EXEC, EN_NONE));
        step("lui.wb", 1'b0, 1'b0, 1'b0, 1'b0, mk(WB, EN_RW | EN_PC, 2'b00, 2'b01));
        check("lui.instret", instret, 32'd9);

        // ihit on the 4th FETCH cycle still decodes
        imemload = 32'h00221821; cur_af = AF_ADDU;
        step("late.f1", 1'b0, 1'b0, 1'b0, 1'b0, mk(FETCH, EN_I));
        step("late.f2", 1'b0, 1'b0, 1'b0, 1'b0, mk(FETCH, EN_I));
        step("late.f3", 1'b0, 1'b0, 1'b0, 1'b0, mk(FETCH, EN_I));
        step("late.f4", 1'b1, 1'b0, 1'b0, 1'b0, mk(FETCH, EN_I));
        step("late.d",  1'b0, 1'b0, 1'b0, 1'b0, mk(DECODE, EN_NONE));
        step("late.e",  1'b0, 1'b0, 1'b0, 1'b0, mk(EXEC, EN_NONE));
        step("late.wb", 1'b0, 1'b0, 1'b0, 1'b0, mk(WB, EN_RW | EN_PC));
        check("late.instret", instret, 32'd10);

        // Fetch timeout: 4 FETCH cycles without ihit, then sticky error halt
        for (int i = 0; i < 4; i++)
            step($sformatf("tmo.f%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, mk(FETCH, EN_I));
        for (int i = 0; i < 20; i++)
            step($sformatf("tmo.h%0d", i), 1'b1, 1'b1, 1'b1, 1'b0,
                 mk(HALT, EN_NONE, 2'b00, 2'b00, 2'b00, 2'b11));
        check("tmo.instret", instret, 32'd10);
        do_reset("tmo.rst", HALT, 2'b11);

        // HALT opcode: halt without err
        imemload = 32'hFC000000;
        fetch_decode("hlt");
        for (int i = 0; i < 20; i++)
            step($sformatf("hlt.h%0d", i), 1'b1, 1'b1, 1'b1, 1'b0,
                 mk(HALT, EN_NONE, 2'b00, 2'b00, 2'b00, 2'b10));
        do_reset("hlt.rst", HALT, 2'b10);

        // Illegal opcode
        imemload = 32'h7C000000;
        fetch_decode("ill");
        for (int i = 0; i < 20; i++)
            step($sformatf("ill.h%0d", i), 1'b1, 1'b1, 1'b1, 1'b0,
                 mk(HALT, EN_NONE, 2'b00, 2'b00, 2'b00, 2'b11));
        do_reset("ill.rst", HALT, 2'b11);

        // R-type with unknown funct
        imemload = 32'h0000003F;
        fetch_decode("fn");
        step("fn.h0", 1'b1, 1'b1, 1'b0, 1'b0, mk(HALT, EN_NONE, 2'b00, 2'b00, 2'b00, 2'b11));
        do_reset("fn.rst", HALT, 2'b11);

        // RST pulse during MEM of SW aborts without committing
        run_addu("pre");
        check("pre.instret", instret, 32'd1);
        imemload = 32'hAC220004; cur_af = AF_MEM;
        fetch_decode("swr");
        step("swr.e",  1'b0, 1'b0, 1'b0, 1'b0, mk(EXEC, EN_NONE));
        step("swr.m1", 1'b0, 1'b0, 1'b0, 1'b0, mk(MEM, EN_DW));
        step("swr.m2", 1'b0, 1'b1, 1'b0, 1'b1, mk(MEM, EN_NONE));
        RST = 1'b0;
        check("swr.state",   32'(state), 32'(FETCH));
        check("swr.ir",      ir, 32'h0);
        check("swr.instret", instret, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
